// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads have strict priority, CPU accesses fill idle slots.
// Optional starvation flag enabled by defining VRAM_STARVE_FLAG_EN.
module vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              CLK_25MHZ,
  input  logic              RESET,
  input  logic              VID_REQ,
  input  logic [ADDR_W-1:0] VID_ADDR,
  output logic [DATA_W-1:0] VID_DATA,
  output logic              VID_VALID,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              CPU_ACK,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA
`ifdef VRAM_STARVE_FLAG_EN
  ,
  output logic              CPU_STARVED
`endif
);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_VID, SLOT_CPU} slot_t;

  slot_t             slot;
  slot_t             slot_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              vid_valid_q;
  logic              cpu_ack_q;
  logic              cpu_rd_q;
  logic [DATA_W-1:0] vid_hold;
  logic [DATA_W-1:0] cpu_hold;
  logic              cpu_busy;

  assign cpu_busy = (slot_q == SLOT_CPU);

  // The ACK cycle is also blocked so a held CPU_REQ is only re-granted the cycle after ACK.
  always_comb begin
    slot = SLOT_IDLE;
    if (VID_REQ) begin
      slot = SLOT_VID;
    end else if (CPU_REQ && !cpu_busy && !cpu_ack_q) begin
      slot = SLOT_CPU;
    end
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      slot_q      <= SLOT_IDLE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      vid_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rd_q    <= 1'b0;
      vid_hold    <= '0;
      cpu_hold    <= '0;
    end else begin
      slot_q   <= slot;
      ram_we_q <= 1'b0;
      case (slot)
        SLOT_VID: ram_addr_q <= VID_ADDR;
        SLOT_CPU: begin
          ram_addr_q  <= CPU_ADDR;
          ram_we_q    <= CPU_WE;
          ram_wdata_q <= CPU_WDATA;
        end
        default: ;
      endcase
      vid_valid_q <= (slot_q == SLOT_VID);
      cpu_ack_q   <= cpu_busy;
      cpu_rd_q    <= cpu_busy && !ram_we_q;
      if (vid_valid_q) vid_hold <= RAM_RDATA;
      if (cpu_rd_q) cpu_hold <= RAM_RDATA;
    end
  end

  // Read data is passed straight from the RAM in the valid cycle and held afterwards.
  assign VID_VALID = vid_valid_q && !RESET;
  assign VID_DATA  = VID_VALID ? RAM_RDATA : vid_hold;
  assign CPU_ACK   = cpu_ack_q && !RESET;
  assign CPU_RDATA = (CPU_ACK && cpu_rd_q) ? RAM_RDATA : cpu_hold;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WE    = ram_we_q && !RESET;
  assign RAM_WDATA = ram_wdata_q;

`ifdef VRAM_STARVE_FLAG_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_next;
  logic             waiting;
  logic             starved;

  assign waiting   = CPU_REQ && !cpu_busy && (slot != SLOT_CPU);
  assign wait_next = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      wait_cnt <= '0;
      starved  <= 1'b0;
    end else if (slot == SLOT_CPU) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      wait_cnt <= wait_next;
      if (wait_next == LIMIT) starved <= 1'b1;
    end
  end

  assign CPU_STARVED = starved;
`else
  if (STARVE_LIMIT > 0) begin : g_starve_unused
  end
`endif

endmodule
